// File: rtl/router_sync_pkg.sv
// Shared definitions for the 1x3 router: destination encodings and watchdog sizing.
package router_sync_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_P0 = 2'd0;
  localparam addr_t ADDR_P1 = 2'd1;
  localparam addr_t ADDR_P2 = 2'd2;

  localparam int unsigned TIMEOUT = 30;
  localparam int unsigned CNT_W   = 5;

endpackage

// File: rtl/router_sync_if.sv
// Signal bundle between router FSM/FIFOs and the sync block.
// The slave side is the sync block; the master side drives FSM and FIFO status.
interface router_sync_if;
  import router_sync_pkg::*;

  logic       detect_add;
  addr_t      data_in;
  logic       write_enb_reg;
  logic       full_0, full_1, full_2;
  logic       empty_0, empty_1, empty_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  modport master (
    output detect_add, data_in, write_enb_reg,
    output full_0, full_1, full_2, empty_0, empty_1, empty_2,
    output read_enb_0, read_enb_1, read_enb_2,
    input  write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  full_0, full_1, full_2, empty_0, empty_1, empty_2,
    input  read_enb_0, read_enb_1, read_enb_2,
    output write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

endinterface

// File: rtl/router_sync_timer.sv
// Per-port read watchdog: pulses soft_reset_o for one cycle after Timeout
// consecutive edges of valid-but-unread data.
module router_sync_timer #(
  parameter int unsigned Timeout = 30,
  parameter int unsigned CntW    = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld_out_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (vld_out_i && !read_enb_i) begin
      // Counter wraps to zero on the pulse so a stuck port re-fires every Timeout cycles.
      if (cnt_q == CntMax) pulse_d = 1'b1;
      else                 cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset_o = pulse_q;

endmodule

// File: rtl/router_sync.sv
// Router sync glue: latches destination, decodes FIFO write enables, muxes the
// addressed full flag, and runs three independent read watchdogs.
module router_sync
  import router_sync_pkg::*;
#(
  parameter int unsigned Timeout = TIMEOUT,
  parameter int unsigned CntW    = CNT_W
) (
  input  logic         clock,
  input  logic         resetn,
  router_sync_if.slave bus
);

  addr_t addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) addr_d = bus.data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) addr_q <= ADDR_P0;
    else         addr_q <= addr_d;
  end

  // Address 3 is invalid: no FIFO is written and full reads back as 0.
  always_comb begin
    bus.write_enb = 3'b000;
    bus.fifo_full = 1'b0;
    case (addr_q)
      ADDR_P0: begin
        bus.write_enb = {2'b00, bus.write_enb_reg};
        bus.fifo_full = bus.full_0;
      end
      ADDR_P1: begin
        bus.write_enb = {1'b0, bus.write_enb_reg, 1'b0};
        bus.fifo_full = bus.full_1;
      end
      ADDR_P2: begin
        bus.write_enb = {bus.write_enb_reg, 2'b00};
        bus.fifo_full = bus.full_2;
      end
      default: begin
        bus.write_enb = 3'b000;
        bus.fifo_full = 1'b0;
      end
    endcase
  end

  assign bus.vld_out_0 = ~bus.empty_0;
  assign bus.vld_out_1 = ~bus.empty_1;
  assign bus.vld_out_2 = ~bus.empty_2;

  router_sync_timer #(.Timeout(Timeout), .CntW(CntW)) u_timer_0 (
    .clock        (clock),
    .resetn       (resetn),
    .vld_out_i    (~bus.empty_0),
    .read_enb_i   (bus.read_enb_0),
    .soft_reset_o (bus.soft_reset_0)
  );

  router_sync_timer #(.Timeout(Timeout), .CntW(CntW)) u_timer_1 (
    .clock        (clock),
    .resetn       (resetn),
    .vld_out_i    (~bus.empty_1),
    .read_enb_i   (bus.read_enb_1),
    .soft_reset_o (bus.soft_reset_1)
  );

  router_sync_timer #(.Timeout(Timeout), .CntW(CntW)) u_timer_2 (
    .clock        (clock),
    .resetn       (resetn),
    .vld_out_i    (~bus.empty_2),
    .read_enb_i   (bus.read_enb_2),
    .soft_reset_o (bus.soft_reset_2)
  );

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: address decode, full mux, valid flags and watchdogs.
module tb_router_sync;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  router_sync_if bus ();

  router_sync dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'd0;
    bus.write_enb_reg = 1'b0;
    {bus.full_0, bus.full_1, bus.full_2}             = 3'b000;
    {bus.empty_0, bus.empty_1, bus.empty_2}          = 3'b111;
    {bus.read_enb_0, bus.read_enb_1, bus.read_enb_2} = 3'b000;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #10;
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.empty_2 = 1'b0;
    step();
    step();
    @(negedge clock);
    resetn            = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full_0        = 1'b1;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd2;
    #10;
    checks++;
    if (bus.write_enb !== 3'b001) begin
      failures++;
      $display("FAIL reset_write_enb got=%b want=001", bus.write_enb);
    end
    checks++;
    if (bus.fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL reset_fifo_full got=%b want=1", bus.fifo_full);
    end
    checks++;
    if ({bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2} !== 3'b000) begin
      failures++;
      $display("FAIL reset_soft_reset got=%b want=000",
               {bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2});
    end
    bus.full_0 = 1'b0;
    #1;
    checks++;
    if (bus.fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_fifo_full_follow got=%b want=0", bus.fifo_full);
    end
    idle_inputs();
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_addr_enable();
    idle_inputs();
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd2;
    bus.write_enb_reg = 1'b1;
    bus.full_0 = 1'b0; bus.full_1 = 1'b1; bus.full_2 = 1'b1;
    step();
    bus.detect_add = 1'b0;
    #1;
    checks++;
    if (bus.write_enb !== 3'b100) begin
      failures++;
      $display("FAIL addr2_write_enb got=%b want=100", bus.write_enb);
    end
    checks++;
    if (bus.fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL addr2_fifo_full got=%b want=1", bus.fifo_full);
    end
    bus.full_2 = 1'b0;
    #1;
    checks++;
    if (bus.fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL addr2_fifo_full_mux got=%b want=0", bus.fifo_full);
    end
    bus.write_enb_reg = 1'b0;
    #1;
    checks++;
    if (bus.write_enb !== 3'b000) begin
      failures++;
      $display("FAIL addr2_no_req got=%b want=000", bus.write_enb);
    end
  endtask

  task automatic test_addr_hold_invalid();
    idle_inputs();
    bus.write_enb_reg = 1'b1;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd1;
    bus.full_1        = 1'b1;
    step();
    bus.detect_add = 1'b0;
    bus.data_in    = 2'd0;
    step();
    step();
    checks++;
    if (bus.write_enb !== 3'b010) begin
      failures++;
      $display("FAIL addr_hold_write_enb got=%b want=010", bus.write_enb);
    end
    checks++;
    if (bus.fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL addr_hold_fifo_full got=%b want=1", bus.fifo_full);
    end
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd3;
    {bus.full_0, bus.full_1, bus.full_2} = 3'b111;
    step();
    bus.detect_add = 1'b0;
    #1;
    checks++;
    if (bus.write_enb !== 3'b000) begin
      failures++;
      $display("FAIL addr3_write_enb got=%b want=000", bus.write_enb);
    end
    checks++;
    if (bus.fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL addr3_fifo_full got=%b want=0", bus.fifo_full);
    end
    idle_inputs();
  endtask

  task automatic test_valid_flags();
    logic [2:0] pats [3];
    logic [2:0] got;
    pats[0] = 3'b001; // {empty_2, empty_1, empty_0}
    pats[1] = 3'b110;
    pats[2] = 3'b010;
    for (int i = 0; i < 3; i++) begin
      {bus.empty_2, bus.empty_1, bus.empty_0} = pats[i];
      #1;
      got = {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
      checks++;
      if (got !== ~pats[i]) begin
        failures++;
        $display("FAIL vld_out pat%0d got=%b want=%b", i, got, ~pats[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [2:0] got;
    logic [2:0] want;
    do_reset();
    idle_inputs();
    bus.empty_0 = 1'b1;
    bus.empty_1 = 1'b0; bus.read_enb_1 = 1'b1;
    bus.empty_2 = 1'b0; bus.read_enb_2 = 1'b0;
    for (int n = 1; n <= 90; n++) begin
      step();
      got  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      want = (n % 30 == 0) ? 3'b100 : 3'b000;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL timeout edge%0d got=%b want=%b", n, got, want);
      end
    end
    idle_inputs();
  endtask

  task automatic test_timeout_restart();
    do_reset();
    idle_inputs();
    bus.empty_2 = 1'b0;
    for (int n = 1; n <= 29; n++) step();
    checks++;
    if (bus.soft_reset_2 !== 1'b0) begin
      failures++;
      $display("FAIL restart_pre got=%b want=0", bus.soft_reset_2);
    end
    bus.read_enb_2 = 1'b1;
    step();
    bus.read_enb_2 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      checks++;
      if (bus.soft_reset_2 !== (n == 30)) begin
        failures++;
        $display("FAIL restart edge%0d got=%b want=%b", n, bus.soft_reset_2, (n == 30));
      end
    end
    idle_inputs();
  endtask

  task automatic test_midcount_reset_and_all_ports();
    logic [2:0] got;
    do_reset();
    idle_inputs();
    {bus.empty_0, bus.empty_1, bus.empty_2} = 3'b000;
    for (int n = 1; n <= 15; n++) step();
    do_reset();
    // Counts restart from zero, so all three ports fire together 30 edges later.
    for (int n = 1; n <= 30; n++) begin
      step();
      got = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      checks++;
      if (got !== ((n == 30) ? 3'b111 : 3'b000)) begin
        failures++;
        $display("FAIL all_ports edge%0d got=%b want=%b", n, got,
                 (n == 30) ? 3'b111 : 3'b000);
      end
    end
    resetn = 1'b0;
    #1;
    got = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    checks++;
    if (got !== 3'b000) begin
      failures++;
      $display("FAIL async_clear got=%b want=000", got);
    end
    resetn = 1'b1;
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    idle_inputs();
    #12;
    resetn = 1'b1;
    test_reset();
    test_addr_enable();
    test_addr_hold_invalid();
    test_valid_flags();
    test_timeout();
    test_timeout_restart();
    test_midcount_reset_and_all_ports();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_sync.md
Name: router_sync

Overview:
Synchronizer/glue block of the 1x3 packet router, sitting between the router FSM/register path and the three output FIFOs. Latches the destination address at packet start and generates one-hot FIFO write enables. Muxes the addressed FIFO's full flag back to the FSM and drives per-port valid-out from FIFO empty flags. Runs per-port read-timeout watchdogs that issue soft resets to FIFOs whose data is not drained.

Parameters:
TIMEOUT, 30, consecutive unread valid cycles before soft_reset_x pulses
CNT_W, 5, width of each per-port timeout counter (must hold TIMEOUT-1)

Ports:
clock  in  1  system clock, all state rising-edge
resetn  in  1  asynchronous active-low reset
detect_add  in  1  packet-start strobe; latch data_in as destination
data_in  in  2  destination address (0,1,2 valid; 3 invalid)
write_enb_reg  in  1  FSM request to write current byte to addressed FIFO
full_0/full_1/full_2  in  1 each  FIFO full flags
empty_0/empty_1/empty_2  in  1 each  FIFO empty flags
read_enb_0/read_enb_1/read_enb_2  in  1 each  downstream read enables
write_enb  out  3  one-hot FIFO write enable
fifo_full  out  1  full flag of addressed FIFO
vld_out_0/vld_out_1/vld_out_2  out  1 each  FIFO x holds data
soft_reset_0/soft_reset_1/soft_reset_2  out  1 each  one-cycle timeout reset to FIFO x

Behaviour:
- Clock is clock; reset is resetn, asynchronous, active-low. Reset: address register = 2'b00, all counters = 0, all soft_reset_x = 0.
- Address register: on rising edge with detect_add=1, addr <= data_in; otherwise holds. No other update source.
- write_enb (combinational from addr, write_enb_reg): write_enb_reg=0 -> 3'b000; else addr 0 -> 001, 1 -> 010, 2 -> 100, 3 -> 000.
- fifo_full (combinational): addr 0/1/2 -> full_0/full_1/full_2; addr 3 -> 0.
- vld_out_x = ~empty_x, combinational, independent of address/reset state.
- Timeout watchdog, per port x, registered:
  - vld_out_x=0 or read_enb_x=1: count_x <= 0, soft_reset_x <= 0.
  - vld_out_x=1 and read_enb_x=0: if count_x == TIMEOUT-1 then soft_reset_x <= 1, count_x <= 0; else count_x <= count_x+1, soft_reset_x <= 0.
  - soft_reset_x is high exactly one cycle, in the cycle after the 30th consecutive idle-valid edge. If the condition persists, the next pulse follows 30 cycles later (period 30 cycles).
  - A single read_enb_x=1 cycle or empty_x=1 cycle restarts the count from 0.
- Ports are fully independent; simultaneous timeouts on multiple ports all pulse.
- Asserting resetn low mid-count clears the counter and any pulse immediately.
- No soft_reset feedback into the address register or write_enb. Upstream FSM handles packet drop.

Decomposition:
- Shared router package: address encodings (ADDR_P0=0, ADDR_P1=1, ADDR_P2=2), TIMEOUT=30, CNT_W=5.
- One natural sub-module, router_sync_timer: single-port counter plus pulse (inputs vld_out, read_enb; output soft_reset), instantiated three times.
- Address latch and muxes stay in the top level.

Test Plan:
- Reset: resetn=0 for 10 ns with any inputs -> soft_reset_x=0, addr=0. With write_enb_reg=1, write_enb=001 and fifo_full=full_0.
- Address/enable: detect_add=1, data_in=2, write_enb_reg=1, full={0,1,1} -> after one edge write_enb=100, fifo_full=1. Then drop write_enb_reg -> write_enb=000.
- Address hold/invalid: latch 1, change data_in with detect_add=0 -> write_enb stays 010. Latch 3 -> write_enb=000, fifo_full=0.
- Valid flags: empty={0:1,1:0,2:0} -> vld_out_0=0, vld_out_1=1, vld_out_2=1, combinationally.
- Timeout: port 2 vld=1, read_enb_2=0 held; port 1 vld=1, read_enb_1=1; port 0 empty -> soft_reset_2 high one cycle after 30 edges and again every 30 cycles. soft_reset_0 and soft_reset_1 never assert.
- Timeout restart: port 2 idle 29 edges, one cycle read_enb_2=1, then idle -> no pulse until 30 further idle edges.
